// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver: hex or double-dabble decimal digit buffer, paged scan.
// Optional build macro SEG7_ZERO_BLANK_EN blanks leading zero digits at every buffer update.
module seg7_scan_display #(
  parameter int DATA_W      = 32,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  input  logic                  dec_mode,
  input  logic [1:0]            page,
  output logic                  busy,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int BUF_DIGITS = (DATA_W + 2) / 3;
  localparam int HEX_DIGITS = DATA_W / 4;
  localparam int BCD_W      = BUF_DIGITS * 4;
  localparam int RW         = $clog2(REFRESH_DIV);
  localparam int KW         = $clog2(NUM_DIGITS);
  localparam int BW         = $clog2(DATA_W);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t                  r_state, w_state_next;
  logic [RW-1:0]           r_cnt, w_cnt_next;
  logic [KW-1:0]           r_k, w_k_next;
  logic [BCD_W-1:0]        r_digits, w_new_digits;
  logic [BUF_DIGITS-1:0]   r_blank, w_new_blank;
  logic                    w_buf_we;
  logic                    w_start_dec, w_hex_load, w_conv_done;
  logic [DATA_W-1:0]       r_shift;
  logic [BCD_W-1:0]        r_bcd, w_bcd_next;
  logic [BW-1:0]           r_bit;
  logic [BCD_W-1:0]        w_val_ext;
  logic [3:0]              w_sel_dig;
  logic                    w_sel_blank;
  int                      w_idx;

  function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return blank ? 7'b1111111 : s;
  endfunction

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift the next bit in.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic b);
    logic [BCD_W-1:0] t;
    t = bcd;
    for (int i = 0; i < BUF_DIGITS; i++)
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    return {t[BCD_W-2:0], b};
  endfunction

`ifdef SEG7_ZERO_BLANK_EN
  function automatic logic [BUF_DIGITS-1:0] lead_blank(input logic [BCD_W-1:0] d,
                                                       input logic [BUF_DIGITS-1:0] b);
    logic [BUF_DIGITS-1:0] r;
    logic                  nz;
    r  = b;
    nz = 1'b0;
    for (int i = BUF_DIGITS - 1; i >= 1; i--) begin
      if (!b[i] && (d[i*4 +: 4] != 4'd0)) nz = 1'b1;
      if (!nz) r[i] = 1'b1;
    end
    return r;
  endfunction
`endif

  assign busy       = (r_state == S_CONV);
  assign w_val_ext  = BCD_W'(value);
  assign w_bcd_next = dd_step(r_bcd, r_shift[DATA_W-1]);

  always_comb begin
    w_state_next = r_state;
    w_start_dec  = 1'b0;
    w_hex_load   = 1'b0;
    w_conv_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load && dec_mode) begin
          w_start_dec  = 1'b1;
          w_state_next = S_CONV;
        end else if (load) begin
          w_hex_load = 1'b1;
        end
      end
      S_CONV: begin
        if (r_bit == '0) begin
          w_conv_done  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_buf_we     = 1'b0;
    w_new_digits = r_digits;
    w_new_blank  = r_blank;
    if (w_hex_load) begin
      w_buf_we     = 1'b1;
      w_new_digits = w_val_ext;
      for (int i = 0; i < BUF_DIGITS; i++) w_new_blank[i] = (i >= HEX_DIGITS);
    end else if (w_conv_done) begin
      w_buf_we     = 1'b1;
      w_new_digits = w_bcd_next;
      w_new_blank  = '0;
    end
`ifdef SEG7_ZERO_BLANK_EN
    w_new_blank = lead_blank(w_new_digits, w_new_blank);
`endif
  end

  // Scan: the registered outputs follow the advanced index but the pre-update buffer.
  always_comb begin
    w_cnt_next = r_cnt + 1'b1;
    w_k_next   = r_k;
    if (r_cnt == RW'(REFRESH_DIV - 1)) begin
      w_cnt_next = '0;
      w_k_next   = (r_k == KW'(NUM_DIGITS - 1)) ? '0 : r_k + 1'b1;
    end
    w_idx       = int'(page) * NUM_DIGITS + int'(w_k_next);
    w_sel_dig   = 4'd0;
    w_sel_blank = 1'b1;
    for (int i = 0; i < BUF_DIGITS; i++) begin
      if (i == w_idx) begin
        w_sel_dig   = r_digits[i*4 +: 4];
        w_sel_blank = r_blank[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_k      <= '0;
      an_n     <= '1;
      seg_n    <= 7'b1111111;
      r_digits <= '0;
      r_blank  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_k     <= w_k_next;
      an_n    <= ~(NUM_DIGITS'(1) << w_k_next);
      seg_n   <= seg_decode(w_sel_dig, w_sel_blank);
      if (w_buf_we) begin
        r_digits <= w_new_digits;
        r_blank  <= w_new_blank;
      end
    end
  end

  // Conversion working registers; the FSM state alone decides whether they matter.
  always_ff @(posedge clk) begin
    if (w_start_dec) begin
      r_shift <= value;
      r_bcd   <= '0;
      r_bit   <= BW'(DATA_W - 1);
    end else if (r_state == S_CONV) begin
      r_shift <= r_shift << 1;
      r_bcd   <= w_bcd_next;
      r_bit   <= r_bit - 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (REFRESH_DIV=4, DATA_W=32, NUM_DIGITS=4).
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] value;
  logic        dec_mode;
  logic [1:0]  page;
  logic        busy;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SEG7_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h01;
`endif

  localparam logic [6:0] S0 = 7'h01, S1 = 7'h4F, S2 = 7'h12, S3 = 7'h06, S4 = 7'h4C,
                         S5 = 7'h24, S6 = 7'h20, S7 = 7'h0F, S9 = 7'h04, SA = 7'h08,
                         SB = 7'h60, SC = 7'h31, SD = 7'h42, BL = 7'h7F;

  seg7_scan_display #(.DATA_W(32), .NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dec_mode(dec_mode),
    .page(page), .busy(busy), .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string tag, input int k, input logic [6:0] exp);
    logic [3:0] want;
    int         n;
    want = ~(4'b0001 << k);
    n    = 0;
    while (an_n !== want && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_an"}, 32'(an_n), 32'(want));
    check(tag, 32'(seg_n), 32'(exp));
  endtask

  task automatic set_page(input logic [1:0] p);
    page = p;
    tick();
    tick();
  endtask

  task automatic do_load(input logic [31:0] v, input logic dm);
    value    = v;
    dec_mode = dm;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    int cyc;
    reset = 1'b1; load = 1'b0; value = '0; dec_mode = 1'b0; page = 2'd0;
    tick(); tick(); tick();
    check("rst_an", 32'(an_n), 32'hF);
    check("rst_seg", 32'(seg_n), 32'(BL));
    check("rst_busy", 32'(busy), 32'd0);

    reset = 1'b0;
    tick();
    check("rel_an", 32'(an_n), 32'hE);
    check("rel_seg", 32'(seg_n), 32'(S0));
    tick(); tick();
    check("rel_an_e3", 32'(an_n), 32'hE);
    tick();
    check("rot_an_e4", 32'(an_n), 32'hD);
    tick(); tick(); tick(); tick();
    check("rot_an_e8", 32'(an_n), 32'hB);

    do_load(32'h1234ABCD, 1'b0);
    check("hex_busy", 32'(busy), 32'd0);
    set_page(2'd0);
    show("hx_p0_d0", 0, SD); show("hx_p0_d1", 1, SC);
    show("hx_p0_d2", 2, SB); show("hx_p0_d3", 3, SA);
    set_page(2'd1);
    show("hx_p1_d0", 0, S4); show("hx_p1_d1", 1, S3);
    show("hx_p1_d2", 2, S2); show("hx_p1_d3", 3, S1);
    set_page(2'd2);
    show("hx_p2_d0", 0, BL); show("hx_p2_d1", 1, BL);
    show("hx_p2_d2", 2, BL); show("hx_p2_d3", 3, BL);

    do_load(32'hFFFFFFFF, 1'b1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        value = 32'h55; dec_mode = 1'b0; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      cyc++;
      tick();
    end
    load = 1'b0;
    check("dec_busy_cycles", 32'(cyc), 32'd32);
    set_page(2'd0);
    show("dc_p0_d0", 0, S5); show("dc_p0_d1", 1, S9);
    show("dc_p0_d2", 2, S2); show("dc_p0_d3", 3, S7);
    set_page(2'd1);
    show("dc_p1_d0", 0, S6); show("dc_p1_d1", 1, S9);
    show("dc_p1_d2", 2, S4); show("dc_p1_d3", 3, S9);
    set_page(2'd2);
    show("dc_p2_d0", 0, S2); show("dc_p2_d1", 1, S4);
    show("dc_p2_d2", 2, LZ); show("dc_p2_d3", 3, BL);

    do_load(32'd12345, 1'b1);
    check("abort_busy_pre", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(an_n), 32'hF);
    check("abort_seg", 32'(seg_n), 32'(BL));
    reset = 1'b0;
    set_page(2'd0);
    show("ab_d0", 0, S0); show("ab_d1", 1, S0);
    show("ab_d2", 2, S0); show("ab_d3", 3, S0);
    for (int i = 0; i < 40; i++) tick();
    check("abort_stays_idle", 32'(busy), 32'd0);

    do_load(32'h00000042, 1'b0);
    tick();
    show("h42_d0", 0, S2); show("h42_d1", 1, S4);
    show("h42_d2", 2, LZ); show("h42_d3", 3, LZ);

    do_load(32'h00000000, 1'b0);
    tick();
    show("h0_d0", 0, S0); show("h0_d1", 1, LZ);
    show("h0_d2", 2, LZ); show("h0_d3", 3, LZ);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
